// File: rtl/bsg_nonsynth_reset_sequencer.sv
// Holds every channel in reset, releases them on a stagger, waits for tag programming, then frees the host.
// Define BSG_MACHINE_RESET_SEQ_TIMEOUT_EN to bound the WAIT_TAG dwell and report timeout_o.
module bsg_nonsynth_reset_sequencer #(
  parameter int num_channels_p   = 4,
  parameter int reset_cycles_p   = 16,
  parameter int stagger_cycles_p = 0,
  parameter int settle_cycles_p  = 3,
  parameter int timeout_cycles_p = 100000
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  output logic [num_channels_p-1:0] chan_reset_o,
  output logic                      host_reset_o,
  output logic [num_channels_p-1:0] tag_done_r_o,
  output logic                      done_o,
  output logic                      timeout_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int max_cnt_lp = max_of(max_of(reset_cycles_p, stagger_cycles_p * num_channels_p),
                                     max_of(settle_cycles_p, timeout_cycles_p));
  localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);

  localparam logic [cnt_w_lp-1:0] reset_last_lp   = cnt_w_lp'(reset_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] stagger_last_lp = cnt_w_lp'(stagger_cycles_p * (num_channels_p - 1));
  localparam logic [cnt_w_lp-1:0] settle_last_lp  = cnt_w_lp'(settle_cycles_p - 1);

  typedef enum logic [2:0] {
    RESET_ASSERT,
    STAGGER,
    WAIT_TAG,
    SETTLE,
    DONE,
    TIMEOUT
  } state_e;

  state_e                    state_r, state_n;
  logic [cnt_w_lp-1:0]       cnt_r, cnt_n;
  logic [num_channels_p-1:0] chan_reset_n, tag_done_n;
  logic                      host_reset_n, done_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= RESET_ASSERT;
      cnt_r        <= '0;
      chan_reset_o <= '1;
      host_reset_o <= 1'b1;
      tag_done_r_o <= '0;
      done_o       <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      chan_reset_o <= chan_reset_n;
      host_reset_o <= host_reset_n;
      tag_done_r_o <= tag_done_n;
      done_o       <= done_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r + cnt_w_lp'(1);
    chan_reset_n = chan_reset_o;
    host_reset_n = host_reset_o;
    done_n       = done_o;
    tag_done_n   = tag_done_r_o;
    // A channel's done level only counts once its own reset has been released.
    if (state_r != DONE && state_r != TIMEOUT)
      tag_done_n = tag_done_r_o | (tag_done_i & ~chan_reset_o);

    if (start_i) begin
      state_n      = RESET_ASSERT;
      cnt_n        = '0;
      chan_reset_n = '1;
      host_reset_n = 1'b1;
      done_n       = 1'b0;
      tag_done_n   = '0;
    end else begin
      case (state_r)
        RESET_ASSERT: if (cnt_r == reset_last_lp) begin
          state_n = STAGGER;
          cnt_n   = '0;
        end
        STAGGER: if (cnt_r == stagger_last_lp) begin
          state_n = WAIT_TAG;
          cnt_n   = '0;
        end
        WAIT_TAG: begin
          if (&tag_done_r_o) begin
            state_n = SETTLE;
            cnt_n   = '0;
          end
`ifdef BSG_MACHINE_RESET_SEQ_TIMEOUT_EN
          else if (cnt_r == cnt_w_lp'(timeout_cycles_p - 1)) begin
            state_n = TIMEOUT;
            cnt_n   = '0;
          end
`endif
        end
        SETTLE: if (cnt_r == settle_last_lp) begin
          state_n      = DONE;
          cnt_n        = '0;
          host_reset_n = 1'b0;
          done_n       = 1'b1;
        end
        DONE, TIMEOUT: cnt_n = cnt_r;
        default: begin
          state_n = RESET_ASSERT;
          cnt_n   = '0;
        end
      endcase

      // Release is registered, so compare against the count the next cycle will hold.
      if (state_n == STAGGER)
        for (int k = 0; k < num_channels_p; k++)
          if (cnt_n >= cnt_w_lp'(k * stagger_cycles_p)) chan_reset_n[k] = 1'b0;
    end
  end

`ifdef BSG_MACHINE_RESET_SEQ_TIMEOUT_EN
  logic timeout_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                    timeout_r <= 1'b0;
    else if (start_i)                               timeout_r <= 1'b0;
    else if (state_r == WAIT_TAG && state_n == TIMEOUT) timeout_r <= 1'b1;
  end

  assign timeout_o = timeout_r;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_nonsynth_reset_sequencer.sv
// Directed bench for bsg_nonsynth_reset_sequencer: expected output vectors are queued per cycle and compared at negedge.
module tb_bsg_nonsynth_reset_sequencer;
  localparam int n_lp       = 4;
  localparam int reset_lp   = 16;
  localparam int stagger_lp = 2;
  localparam int settle_lp  = 3;
  localparam int timeout_lp = 100;
  localparam int never_lp   = 1 << 30;

  logic       clk        = 1'b0;
  logic       reset_i    = 1'b0;
  logic       start_i    = 1'b0;
  logic [3:0] tag_done_i = 4'b0;
  logic [3:0] chan_reset_o, tag_done_r_o;
  logic       host_reset_o, done_o, timeout_o;
  logic [10:0] obs;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [10:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  localparam logic [10:0] reset_vec_lp = {1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111};

  bsg_nonsynth_reset_sequencer #(
    .num_channels_p  (n_lp),
    .reset_cycles_p  (reset_lp),
    .stagger_cycles_p(stagger_lp),
    .settle_cycles_p (settle_lp),
    .timeout_cycles_p(timeout_lp)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .tag_done_i  (tag_done_i),
    .chan_reset_o(chan_reset_o),
    .host_reset_o(host_reset_o),
    .tag_done_r_o(tag_done_r_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  assign obs = {timeout_o, done_o, host_reset_o, tag_done_r_o, chan_reset_o};

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (e.cyc == cyc && obs === e.exp) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, e.cyc, obs, e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d observed=no_finish expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_now(input string tag, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // c0: cycle in which the reset counter holds 0 with reset_i low and start_i low.
  // i_main drives tag_done_i[3,1,0] high, i_late drives tag_done_i[2] high (cycle numbers).
  task automatic run_seq(input string tag, input int c0, input int i_main, input int i_late);
    int s0, w, f, tmo, dn, last, lim;
    int cap[4];
    logic [10:0] v;
    s0 = c0 + reset_lp;
    w  = s0 + (n_lp - 1) * stagger_lp + 1;
    f  = 0;
    for (int k = 0; k < n_lp; k++) begin
      int ik, rel;
      ik     = (k == 2) ? i_late : i_main;
      rel    = s0 + k * stagger_lp;
      cap[k] = ((ik > rel) ? ik : rel) + 1;
      if (cap[k] > f) f = cap[k];
    end
    tmo  = -1;
    dn   = f + settle_lp + 1;
    last = dn + 2;
`ifdef BSG_MACHINE_RESET_SEQ_TIMEOUT_EN
    if (f >= w + timeout_lp) begin
      tmo  = w + timeout_lp;
      dn   = -1;
      last = tmo + 5;
    end
`endif
    for (int t = c0; t <= last; t++) begin
      lim = (tmo >= 0 && t > tmo) ? tmo : t;
      v   = '0;
      for (int k = 0; k < n_lp; k++) begin
        v[k]     = (t < s0 + k * stagger_lp);
        v[4 + k] = (cap[k] <= lim);
      end
      v[9]  = (dn >= 0 && t >= dn);
      v[8]  = !v[9];
      v[10] = (tmo >= 0 && t >= tmo);
      sb.push_back('{t, v, tag});
    end
    forever begin
      if (cyc == i_main) begin
        tag_done_i[0] = 1'b1;
        tag_done_i[1] = 1'b1;
        tag_done_i[3] = 1'b1;
      end
      if (cyc == i_late) tag_done_i[2] = 1'b1;
      if (cyc > last) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c0;
    #1 reset_i = 1'b1;
    #1 check_now("reset_async_entry", reset_vec_lp);
    repeat (3) begin @(posedge clk); #1; end
    check_now("reset_hold", reset_vec_lp);

    // Nominal: tag_done_i rises five cycles after channel 3 release.
    reset_i = 1'b0;
    c0 = cyc;
    run_seq("nominal", c0, c0 + reset_lp + (n_lp - 1) * stagger_lp + 5,
            c0 + reset_lp + (n_lp - 1) * stagger_lp + 5);

    tag_done_i = 4'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_now("done_ignores_tag", {1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000});

    // Single-cycle restart from DONE repeats the same timing.
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    c0 = cyc;
    run_seq("restart", c0, c0 + reset_lp + (n_lp - 1) * stagger_lp + 5,
            c0 + reset_lp + (n_lp - 1) * stagger_lp + 5);

    // Masking: tag_done_i high throughout, captures follow each release.
    tag_done_i = 4'b1111;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    c0 = cyc;
    run_seq("mask", c0, -5, -5);

    // Held start keeps the sequencer parked in reset.
    tag_done_i = 4'b0;
    start_i    = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_now("start_held", reset_vec_lp);
    @(posedge clk); #1;
    start_i = 1'b0;
    c0 = cyc;
`ifdef BSG_MACHINE_RESET_SEQ_TIMEOUT_EN
    run_seq("timeout", c0, c0 + reset_lp + 11, never_lp);
`else
    run_seq("no_timeout", c0, c0 + reset_lp + 11, c0 + reset_lp + 11 + 1000);
`endif

    // Asynchronous reset pulse in the middle of SETTLE.
    tag_done_i = 4'b1111;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    c0 = cyc;
    while (cyc < c0 + reset_lp + 9) begin @(posedge clk); #1; end
    check_now("mid_settle", {1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000});
    #1 reset_i = 1'b1;
    #1 check_now("async_mid_settle", reset_vec_lp);
    reset_i = 1'b0;
    run_seq("after_async", cyc, -5, -5);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
